vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Dispense-side controller that consumes the vend and change strobes produced by the vending-machine FSM and drives the product and coin-return solenoids. Events are queued in a small FIFO so back-to-back sales are not lost. Each queued event is expanded into a sequence of timed solenoid pulses, each confirmed by a mechanism drop sensor. The block sits between the vending FSM outputs and the physical dispense mechanism.

## Interface
- PULSE_CYCLES, 4: solenoid on-time per pulse, in clocks (≥1)
- GAP_CYCLES, 2: idle clocks after each acknowledged pulse (≥1)
- ACK_TIMEOUT, 16: max clocks to wait for drop_ack after a pulse ends (≥1)
- DEPTH, 4: event FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- out  in  1  vend strobe from FSM; one-cycle pulse = one product owed
- change  in  2  change strobe from FSM: 00 none, 01 one 5-coin, 10 one 10-coin, 11 two 10-coins
- drop_ack  in  1  mechanism sensor, one-cycle pulse per item dropped
- prod_fire  out  1  product solenoid drive
- coin5_fire  out  1  5-coin return solenoid drive
- coin10_fire  out  1  10-coin return solenoid drive
- busy  out  1  FIFO non-empty or FSM not IDLE
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- jam  out  1  sticky: ack timeout occurred; dispensing halted

## Operation
- Capture: each clock with out=1 or change≠00 forms an event {out, change}; pushed if FIFO not full, else dropped and overflow set. Push and pop in the same clock are both honored.
- FSM states: IDLE, FIRE, WAIT_ACK, GAP, JAM.
- IDLE: if FIFO non-empty, pop into working registers (prod_pend, n10 ∈ {0,1,2}, n5 ∈ {0,1}), then go to FIRE with the first action selected.
- Action order within an event: product first, then all 10-coins, then the 5-coin.
- FIRE: exactly one of the fire outputs is high for PULSE_CYCLES clocks, then WAIT_ACK.
- WAIT_ACK: all fire outputs low. drop_ack=1 decrements the pending item and moves to GAP. drop_ack is ignored in every other state. If no ack arrives within ACK_TIMEOUT clocks, go to JAM.
- GAP: GAP_CYCLES clocks. Then go to FIRE if the event still has pending items, else IDLE.
- JAM: terminal until rst. Fire outputs low, jam=1, busy=1. Capture continues, and overflow behaves as normal.
- All outputs are registered. The fire outputs are mutually exclusive at all times.
- Reset (asynchronous, at any time including mid-pulse): FIFO emptied, working registers cleared, FSM to IDLE. All outputs go to 0 immediately.

## Timing
- Strobe high in cycle N is pushed at edge N+1. If the FSM is IDLE, the pop happens at edge N+2 and the first fire output is high starting at edge N+2.
- A fire output stays high for exactly PULSE_CYCLES clocks.
- An ack sampled at edge A gives GAP from A. The next fire output rises at A+GAP_CYCLES.
- After the last gap, the FSM is IDLE for one clock before popping the next event.
- Timeout: JAM is entered at the ACK_TIMEOUT-th edge after WAIT_ACK entry with no ack.
- busy falls at the edge on which the FSM returns to IDLE with the FIFO empty.
- Full FIFO plus a same-cycle pop: the new event is accepted and overflow is not set.

## Test plan
- Reset: assert rst asynchronously mid-pulse -> all six outputs 0 within the same cycle; after release, busy=0.
- out=1 with change=01 for one cycle; ack 3 clocks after each pulse -> prod_fire 4 clocks, gap 2, coin5_fire 4 clocks, then busy=0. coin10_fire is never high.
- change=11 alone -> two coin10_fire pulses of 4 clocks each, separated by ack+gap. prod_fire and coin5_fire stay 0.
- Six consecutive out=1 strobes with no acks (DEPTH=4) -> first event popped, next four queued, sixth dropped, overflow=1. With prompt acks afterwards, exactly 5 prod_fire pulses occur.
- prod event with drop_ack held 0 -> one 4-clock pulse, then jam=1 at 16 clocks after pulse end. No further fires; a later event still pushes and busy stays 1.
- Strobe in the same cycle as the FIFO pops its last entry -> the event is accepted with no overflow and is dispensed next.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Dispense-side controller: queues vend/change events in a small FIFO and expands
// each into timed solenoid pulses, each confirmed by a drop sensor acknowledge.
module vend_dispense_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int ACK_TIMEOUT  = 16,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  input  logic       drop_ack,
  output logic       prod_fire,
  output logic       coin5_fire,
  output logic       coin10_fire,
  output logic       busy,
  output logic       overflow,
  output logic       jam
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAXC  = (PULSE_CYCLES > GAP_CYCLES)
                         ? ((PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT)
                         : ((GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT);
  localparam int TW    = $clog2(MAXC + 1);

  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT_ACK,
    S_GAP,
    S_JAM
  } state_e;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;

  logic          push_req, push, pop, fifo_full, fifo_empty;
  logic [2:0]    head;

  state_e        state_q, state_d;

  assign push_req   = out | (|change);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts when the same edge frees a slot.
  assign push       = push_req && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: storage needs no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {out, change};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_q | (push_req && !push);
    end
  end

  // ---------------------------------------------------------------------------
  // Dispense sequencer
  // ---------------------------------------------------------------------------
  logic [TW-1:0] cnt_q, cnt_d;
  logic          prod_q, prod_d;
  logic [1:0]    n10_q, n10_d;
  logic          n5_q, n5_d;
  logic          items_left;

  assign items_left = prod_q || (n10_q != 2'd0) || n5_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    n10_d   = n10_q;
    n5_d    = n5_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          prod_d  = head[2];
          n10_d   = (head[1:0] == 2'b11) ? 2'd2 : ((head[1:0] == 2'b10) ? 2'd1 : 2'd0);
          n5_d    = (head[1:0] == 2'b01);
          cnt_d   = '0;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (drop_ack) begin
          // Retire the item that was just fired: product, then 10-coins, then 5-coin.
          if (prod_q)               prod_d = 1'b0;
          else if (n10_q != 2'd0)   n10_d  = n10_q - 2'd1;
          else                      n5_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_JAM;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = items_left ? S_FIRE : S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_JAM:   state_d = S_JAM;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  logic prod_fire_q, coin5_fire_q, coin10_fire_q, busy_q, jam_q;
  logic firing;

  assign firing = (state_d == S_FIRE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      prod_q        <= 1'b0;
      n10_q         <= 2'd0;
      n5_q          <= 1'b0;
      prod_fire_q   <= 1'b0;
      coin5_fire_q  <= 1'b0;
      coin10_fire_q <= 1'b0;
      busy_q        <= 1'b0;
      jam_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prod_q        <= prod_d;
      n10_q         <= n10_d;
      n5_q          <= n5_d;
      prod_fire_q   <= firing && prod_d;
      coin10_fire_q <= firing && !prod_d && (n10_d != 2'd0);
      coin5_fire_q  <= firing && !prod_d && (n10_d == 2'd0) && n5_d;
      busy_q        <= (count_d != '0) || (state_d != S_IDLE);
      jam_q         <= (state_d == S_JAM);
    end
  end

  assign prod_fire   = prod_fire_q;
  assign coin5_fire  = coin5_fire_q;
  assign coin10_fire = coin10_fire_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;
  assign jam         = jam_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl; output vector is
// {prod_fire, coin5_fire, coin10_fire, busy, overflow, jam}.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe_out;
  logic [1:0] change_in;
  logic       ack_in;
  logic       prod_fire, coin5_fire, coin10_fire, busy, overflow, jam;
  logic [5:0] outv;
  logic [2:0] fires;

  int checks   = 0;
  int failures = 0;

  logic [2:0] kinds [5];

  vend_dispense_ctrl #(
    .PULSE_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(16), .DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .out         (strobe_out),
    .change      (change_in),
    .drop_ack    (ack_in),
    .prod_fire   (prod_fire),
    .coin5_fire  (coin5_fire),
    .coin10_fire (coin10_fire),
    .busy        (busy),
    .overflow    (overflow),
    .jam         (jam)
  );

  assign outv  = {prod_fire, coin5_fire, coin10_fire, busy, overflow, jam};
  assign fires = {prod_fire, coin5_fire, coin10_fire};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0b expected=%0b", tag, got, exp);
    end
  endtask

  // Drive inputs for one cycle, then check outputs just after the edge that samples them.
  task automatic cyc(input logic o, input logic [1:0] ch, input logic ack,
                     input logic [5:0] exp, input string tag);
    strobe_out = o;
    change_in  = ch;
    ack_in     = ack;
    @(posedge clk);
    #1;
    check(tag, outv, exp);
  endtask

  task automatic hold(input int n, input logic [5:0] exp, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, exp, tag);
  endtask

  // Two-item event with the ack arriving 3 clocks after each pulse ends.
  task automatic two_item_event(input logic o, input logic [1:0] ch,
                                input logic [5:0] fv1, input logic [5:0] fv2,
                                input string tag);
    cyc(o, ch, 1'b0, 6'b000100, tag);
    hold(4, fv1, tag);
    hold(3, 6'b000100, tag);
    cyc(1'b0, 2'b00, 1'b1, 6'b000100, tag);
    hold(1, 6'b000100, tag);
    hold(4, fv2, tag);
    hold(3, 6'b000100, tag);
    cyc(1'b0, 2'b00, 1'b1, 6'b000100, tag);
    hold(1, 6'b000100, tag);
    hold(1, 6'b000000, tag);
  endtask

  // Acknowledge five pulses promptly, recording which solenoid fired each time.
  task automatic serve5();
    strobe_out = 1'b0;
    change_in  = 2'b00;
    ack_in     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int t;
      t = 0;
      while (fires == 3'b000 && t < 64) begin
        @(posedge clk); #1; t++;
      end
      kinds[i] = fires;
      t = 0;
      while (fires != 3'b000 && t < 16) begin
        @(posedge clk); #1; t++;
      end
      ack_in = 1'b1;
      @(posedge clk); #1;
      ack_in = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    strobe_out = 1'b0;
    change_in  = 2'b00;
    ack_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outv, 6'b000000);
    rst = 1'b0;
    hold(2, 6'b000000, "reset_idle");

    // Product plus one 5-coin: prod pulse, ack, gap, coin5 pulse, ack, idle.
    two_item_event(1'b1, 2'b01, 6'b100100, 6'b010100, "prod_coin5");

    // Two 10-coins only.
    two_item_event(1'b0, 2'b11, 6'b001100, 6'b001100, "two_coin10");

    // Six back-to-back product strobes: one popped, four queued, sixth dropped.
    cyc(1'b1, 2'b00, 1'b0, 6'b000100, "ovf_push1");
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b0, 6'b100100, "ovf_push_fire");
    cyc(1'b1, 2'b00, 1'b0, 6'b000110, "ovf_drop6");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'b00, 1'b1, 6'b000110, "ovf_ack");
      hold(2, 6'b000110, "ovf_gap_idle");
      hold(1, 6'b100110, "ovf_fire");
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b1, 6'b100110, "ovf_ack_ignored");
      hold(1, 6'b000110, "ovf_wait");
    end
    cyc(1'b0, 2'b00, 1'b1, 6'b000110, "ovf_last_ack");
    hold(1, 6'b000110, "ovf_last_gap");
    hold(1, 6'b000010, "ovf_drained");

    // Asynchronous reset in the middle of a pulse.
    cyc(1'b1, 2'b00, 1'b0, 6'b000110, "arst_push");
    cyc(1'b0, 2'b00, 1'b0, 6'b100110, "arst_fire");
    #3;
    rst = 1'b1;
    #1;
    check("arst_immediate", outv, 6'b000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(2, 6'b000000, "arst_released");

    // Full FIFO and a strobe on the edge that pops: accepted, no overflow, served last.
    cyc(1'b1, 2'b00, 1'b0, 6'b000100, "full_push1");
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b0, 6'b100100, "full_fill");
    hold(1, 6'b000100, "full_wait");
    cyc(1'b0, 2'b00, 1'b1, 6'b000100, "full_ack");
    hold(2, 6'b000100, "full_gap_idle");
    cyc(1'b0, 2'b10, 1'b0, 6'b100100, "full_pop_push");
    hold(1, 6'b100100, "full_no_ovf");
    serve5();
    check("full_kind0", kinds[0], 3'b100);
    check("full_kind1", kinds[1], 3'b100);
    check("full_kind2", kinds[2], 3'b100);
    check("full_kind3", kinds[3], 3'b100);
    check("full_kind4", kinds[4], 3'b001);
    begin
      int t;
      t = 0;
      while (busy && t < 32) begin
        @(posedge clk); #1; t++;
      end
    end
    check("full_end", outv, 6'b000000);

    // Ack never arrives: jam exactly 16 clocks after the pulse ends.
    cyc(1'b1, 2'b00, 1'b0, 6'b000100, "jam_push");
    hold(4, 6'b100100, "jam_fire");
    hold(1, 6'b000100, "jam_wait_entry");
    hold(15, 6'b000100, "jam_wait");
    hold(1, 6'b000101, "jam_enter");
    cyc(1'b0, 2'b00, 1'b1, 6'b000101, "jam_ack_ignored");
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b0, 6'b000101, "jam_capture");
    cyc(1'b1, 2'b00, 1'b0, 6'b000111, "jam_overflow");
    hold(4, 6'b000111, "jam_terminal");

    #3;
    rst = 1'b1;
    #1;
    check("jam_reset", outv, 6'b000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(2, 6'b000000, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
